// File: rtl/pc_fetch.sv
// Program counter and six-slot fetch/execute timing ring for the 4-bit model computer.
// Optional build macro PC_WRAP_HALT_EN: halt instead of wrapping the PC past 15.
module pc_fetch #(
    parameter int NSTATE = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RUN,
    input  logic              HLT,
    input  logic              JMP,
    input  logic [3:0]        JD,
    output logic [3:0]        D_OUT,
    output logic              IMAR,
    output logic              ICE,
    output logic              LIR,
    output logic [NSTATE-1:0] T,
    output logic              HALTED
);

    // The halted slot is the all-zero ring, so T reads 000000 without extra gating.
    typedef enum logic [NSTATE-1:0] {
        S_HALT = 6'b000000,
        S_T0   = 6'b000001,
        S_T1   = 6'b000010,
        S_T2   = 6'b000100,
        S_T3   = 6'b001000,
        S_T4   = 6'b010000,
        S_T5   = 6'b100000
    } state_t;

    state_t     r_t, w_t_nxt;
    logic [3:0] r_pc, w_pc_nxt;
    logic       r_halted, w_halted_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_t      <= S_T0;
            r_pc     <= 4'd0;
            r_halted <= 1'b0;
        end else begin
            r_t      <= w_t_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_t_nxt      = r_t;
        w_pc_nxt     = r_pc;
        w_halted_nxt = r_halted;
        IMAR         = 1'b0;
        ICE          = 1'b0;
        LIR          = 1'b0;
        case (r_t)
            S_T0: begin
                IMAR = RUN;
                if (RUN) w_t_nxt = S_T1;
            end
            S_T1: begin
`ifdef PC_WRAP_HALT_EN
                if (r_pc == 4'hF) begin
                    w_t_nxt      = S_HALT;
                    w_halted_nxt = 1'b1;
                end else begin
                    w_pc_nxt = r_pc + 4'd1;
                    w_t_nxt  = S_T2;
                end
`else
                w_pc_nxt = r_pc + 4'd1;
                w_t_nxt  = S_T2;
`endif
            end
            S_T2: begin
                ICE     = 1'b1;
                LIR     = 1'b1;
                w_t_nxt = S_T3;
            end
            S_T3: begin
                // Halt wins over a simultaneous jump and freezes the PC.
                if (HLT) begin
                    w_t_nxt      = S_HALT;
                    w_halted_nxt = 1'b1;
                end else begin
                    if (JMP) w_pc_nxt = JD;
                    w_t_nxt = S_T4;
                end
            end
            S_T4: begin
                if (JMP) w_pc_nxt = JD;
                w_t_nxt = S_T5;
            end
            S_T5: begin
                if (JMP) w_pc_nxt = JD;
                w_t_nxt = S_T0;
            end
            S_HALT: begin
                w_t_nxt = S_HALT;
            end
            default: begin
                w_t_nxt = S_T0;
            end
        endcase
    end

    assign D_OUT  = r_pc;
    assign T      = r_t;
    assign HALTED = r_halted;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed-vector bench for pc_fetch: run, stall, jump, halt, wrap and async reset.
module tb_pc_fetch;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RUN = 1'b0;
    logic       HLT = 1'b0;
    logic       JMP = 1'b0;
    logic [3:0] JD  = 4'd0;
    logic [3:0] D_OUT;
    logic       IMAR, ICE, LIR, HALTED;
    logic [5:0] T;

    int n_chk = 0;
    int n_err = 0;

    pc_fetch #(.NSTATE(6)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .HLT(HLT), .JMP(JMP), .JD(JD),
        .D_OUT(D_OUT), .IMAR(IMAR), .ICE(ICE), .LIR(LIR), .T(T), .HALTED(HALTED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; land just after the falling edge, well clear of the rising edge.
    task automatic nc();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        // Reset and run
        RUN = 1'b1;
        #2 RST = 1'b1;
        @(negedge CLK); #1;
        check("rst_dout", 8'(D_OUT), 8'd0);
        check("rst_t", 8'(T), 8'h01);
        check("rst_halted", 8'(HALTED), 8'd0);
        check("rst_ice", 8'(ICE), 8'd0);
        check("rst_lir", 8'(LIR), 8'd0);
        check("rst_imar", 8'(IMAR), 8'd1);
        RST = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check("run_t", 8'(T), 8'(6'b1 << (c % 6)));
            check("run_imar", 8'(IMAR), 8'((c % 6) == 0));
            check("run_ice", 8'(ICE), 8'((c % 6) == 2));
            check("run_lir", 8'(LIR), 8'((c % 6) == 2));
            check("run_dout", 8'(D_OUT), 8'((c + 4) / 6));
            nc();
        end

        // Stall with RUN low
        RUN = 1'b0;
        RST = 1'b1; #1 RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("stall_t", 8'(T), 8'h01);
            check("stall_imar", 8'(IMAR), 8'd0);
            check("stall_dout", 8'(D_OUT), 8'd0);
            nc();
        end
        RUN = 1'b1; #1;
        check("stall_imar_up", 8'(IMAR), 8'd1);
        nc();
        check("stall_t1", 8'(T), 8'h02);

        // Jump in T4
        nc(); nc(); nc();
        check("jmp_at_t4", 8'(T), 8'h10);
        JMP = 1'b1; JD = 4'b1010;
        nc();
        check("jmp_t5_dout", 8'(D_OUT), 8'hA);
        JMP = 1'b0;
        nc();
        check("jmp_t0_dout", 8'(D_OUT), 8'hA);
        check("jmp_t0_t", 8'(T), 8'h01);
        check("jmp_t0_imar", 8'(IMAR), 8'd1);
        // Jump in T3 and T5, last one wins
        nc(); nc(); nc();
        JMP = 1'b1; JD = 4'b0011;
        nc();
        check("jmp2_t4_dout", 8'(D_OUT), 8'h3);
        JMP = 1'b0;
        nc();
        JMP = 1'b1; JD = 4'b0101;
        nc();
        JMP = 1'b0;
        check("jmp2_t0_dout", 8'(D_OUT), 8'h5);
        check("jmp2_t0_t", 8'(T), 8'h01);

        // Halt with simultaneous jump at pc=3
        nc(); nc(); nc(); nc();
        JMP = 1'b1; JD = 4'd2;
        nc();
        JMP = 1'b0;
        nc(); nc(); nc(); nc();
        check("hlt_pre_t", 8'(T), 8'h08);
        check("hlt_pre_dout", 8'(D_OUT), 8'h3);
        HLT = 1'b1; JMP = 1'b1; JD = 4'd9;
        nc();
        HLT = 1'b0; JMP = 1'b0;
        check("hlt_halted", 8'(HALTED), 8'd1);
        check("hlt_t", 8'(T), 8'h00);
        check("hlt_dout", 8'(D_OUT), 8'h3);
        for (int i = 0; i < 10; i++) begin
            RUN = ((i % 2) == 0);
            JMP = ((i % 2) == 1);
            HLT = (i == 4);
            JD  = 4'(i + 6);
            #1;
            check("hold_halted", 8'(HALTED), 8'd1);
            check("hold_t", 8'(T), 8'h00);
            check("hold_dout", 8'(D_OUT), 8'h3);
            check("hold_imar", 8'(IMAR), 8'd0);
            check("hold_ice", 8'(ICE), 8'd0);
            nc();
        end
        RUN = 1'b1; JMP = 1'b0; HLT = 1'b0;
        RST = 1'b1; #1;
        check("hrst_dout", 8'(D_OUT), 8'd0);
        check("hrst_t", 8'(T), 8'h01);
        check("hrst_halted", 8'(HALTED), 8'd0);
        RST = 1'b0;

        // Wrap from 15
        nc(); nc(); nc(); nc();
        JMP = 1'b1; JD = 4'hF;
        nc();
        JMP = 1'b0;
        nc();
        check("wrap_t0_dout", 8'(D_OUT), 8'hF);
        nc(); nc();
`ifdef PC_WRAP_HALT_EN
        check("wrap_dout", 8'(D_OUT), 8'hF);
        check("wrap_halted", 8'(HALTED), 8'd1);
        check("wrap_t", 8'(T), 8'h00);
        check("wrap_ice", 8'(ICE), 8'd0);
`else
        check("wrap_dout", 8'(D_OUT), 8'h0);
        check("wrap_halted", 8'(HALTED), 8'd0);
        check("wrap_t", 8'(T), 8'h04);
        check("wrap_ice", 8'(ICE), 8'd1);
`endif

        // Asynchronous reset mid-T2
        RST = 1'b1; #1 RST = 1'b0;
        nc(); nc();
        check("arst_pre_ice", 8'(ICE), 8'd1);
        check("arst_pre_dout", 8'(D_OUT), 8'h1);
        #1 RST = 1'b1;
        #1;
        check("arst_ice", 8'(ICE), 8'd0);
        check("arst_lir", 8'(LIR), 8'd0);
        check("arst_dout", 8'(D_OUT), 8'd0);
        check("arst_t", 8'(T), 8'h01);
        nc();
        RST = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
